// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the directional bus arbiter and its NodeIO peers.
package bus_arbiter_pkg;

  localparam int unsigned CTRL_W = 3;
  localparam logic [CTRL_W-1:0] CTRL_TX   = 3'b100;
  localparam logic [CTRL_W-1:0] CTRL_RX   = 3'b010;
  localparam logic [CTRL_W-1:0] CTRL_BYP  = 3'b001;
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_PROP = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  // Request slice layout is {valid, dest[digits-1:0]}.
  localparam int unsigned REQ_DEST_LSB = 0;

  function automatic int unsigned req_slice_w(int unsigned digits);
    return digits + 1;
  endfunction

  function automatic int unsigned req_valid_ofs(int unsigned digits);
    return digits;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/control bundle between the arbiter and the NodeIO ports of one bus segment.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NODE_COUNT       = 8,
  parameter int unsigned NODE_COUNT_DIGIT = 3,
  parameter int unsigned DROP_CNT_W       = 8
);

  logic [NODE_COUNT*(NODE_COUNT_DIGIT+1)-1:0] request_in;
  logic [NODE_COUNT*CTRL_W-1:0]               control_out;
  logic                                       busy;
  logic [NODE_COUNT_DIGIT-1:0]                grant_node;
  logic [DROP_CNT_W-1:0]                      drop_count;

  modport master (
    input  request_in,
    output control_out, busy, grant_node, drop_count
  );

  modport slave (
    output request_in,
    input  control_out, busy, grant_node, drop_count
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin priority search: first set request after ptr, wrapping at NODE_COUNT-1.
module rr_picker #(
  parameter int unsigned NODE_COUNT       = 8,
  parameter int unsigned NODE_COUNT_DIGIT = 3
) (
  input  logic [NODE_COUNT-1:0]       req,
  input  logic [NODE_COUNT_DIGIT-1:0] ptr,
  output logic                        found,
  output logic [NODE_COUNT_DIGIT-1:0] idx
);

  logic [NODE_COUNT_DIGIT-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NODE_COUNT; k++) begin
      cand = NODE_COUNT_DIGIT'((32'(ptr) + k) % NODE_COUNT);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-transfer arbiter for one directional bus segment: grants a source,
// then walks Tx / bypass / Rx control codes hop by hop to the destination.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NODE_COUNT       = 8,
  parameter int unsigned NODE_COUNT_DIGIT = 3,
  parameter int unsigned DIRECTION        = 0,
  parameter int unsigned DROP_CNT_W       = 8
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master bus
);

  localparam int unsigned D    = NODE_COUNT_DIGIT;
  localparam int unsigned RW   = req_slice_w(D);
  localparam int unsigned VOFS = req_valid_ofs(D);
  localparam int unsigned SW   = DROP_CNT_W + D + 1;

  state_t state, state_nx;

  logic [D-1:0] src, src_nx;
  logic [D-1:0] dst, dst_nx;
  logic [D-1:0] h, h_nx;
  logic [D-1:0] rr_ptr, rr_ptr_nx;
  logic [D-1:0] hops;
  logic [D-1:0] node;

  logic [D-1:0]          req_dest [NODE_COUNT];
  logic [NODE_COUNT-1:0] req_vld;
  logic [NODE_COUNT-1:0] legal_req;
  logic [D:0]            n_drop;
  logic [SW-1:0]         drop_sum;
  logic [DROP_CNT_W-1:0] drop_nx;

  logic         found;
  logic [D-1:0] pick;

  logic [NODE_COUNT*CTRL_W-1:0] ctrl_nx;
  logic                         busy_nx;
  logic [D-1:0]                 grant_nx;

  // Illegal requests (wrong direction or self-addressed) are masked and counted.
  always_comb begin
    legal_req = '0;
    req_vld   = '0;
    n_drop    = '0;
    for (int unsigned n = 0; n < NODE_COUNT; n++) begin
      req_dest[n] = bus.request_in[n*RW + REQ_DEST_LSB +: D];
      req_vld[n]  = bus.request_in[n*RW + VOFS];
      if (DIRECTION == 0) legal_req[n] = req_vld[n] && (req_dest[n] > D'(n));
      else                legal_req[n] = req_vld[n] && (req_dest[n] < D'(n));
      if (req_vld[n] && !legal_req[n]) n_drop = n_drop + 1'b1;
    end
  end

  rr_picker #(
    .NODE_COUNT       (NODE_COUNT),
    .NODE_COUNT_DIGIT (D)
  ) u_rr_picker (
    .req   (legal_req),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  assign hops     = (DIRECTION == 0) ? (dst - src) : (src - dst);
  assign drop_sum = SW'(bus.drop_count) + SW'(n_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    src_nx    = src;
    dst_nx    = dst;
    h_nx      = h;
    rr_ptr_nx = rr_ptr;
    drop_nx   = bus.drop_count;
    unique case (state)
      ST_IDLE: begin
        if (|drop_sum[SW-1:DROP_CNT_W]) drop_nx = '1;
        else                            drop_nx = drop_sum[DROP_CNT_W-1:0];
        if (found) begin
          state_nx  = ST_TX;
          src_nx    = pick;
          dst_nx    = req_dest[pick];
          rr_ptr_nx = pick;
        end
      end
      ST_TX: begin
        state_nx = ST_PROP;
        h_nx     = D'(1);
      end
      ST_PROP: begin
        if (h == hops) begin
          state_nx = ST_COOL;
          h_nx     = '0;
        end else begin
          h_nx = h + 1'b1;
        end
      end
      ST_COOL: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each control
  // code appears in the same cycle as the state it belongs to.
  always_comb begin
    ctrl_nx  = '0;
    busy_nx  = (state_nx != ST_IDLE);
    grant_nx = bus.grant_node;
    node     = '0;
    unique case (state_nx)
      ST_TX: begin
        ctrl_nx[src_nx*CTRL_W +: CTRL_W] = CTRL_TX;
        grant_nx                         = src_nx;
      end
      ST_PROP: begin
        node = (DIRECTION == 0) ? (src_nx + h_nx) : (src_nx - h_nx);
        ctrl_nx[node*CTRL_W +: CTRL_W] = (h_nx == hops) ? CTRL_RX : CTRL_BYP;
      end
      default: ctrl_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src             <= '0;
      dst             <= '0;
      h               <= '0;
      rr_ptr          <= D'(NODE_COUNT - 1);
      bus.control_out <= '0;
      bus.busy        <= 1'b0;
      bus.grant_node  <= '0;
      bus.drop_count  <= '0;
    end else begin
      src             <= src_nx;
      dst             <= dst_nx;
      h               <= h_nx;
      rr_ptr          <= rr_ptr_nx;
      bus.control_out <= ctrl_nx;
      bus.busy        <= busy_nx;
      bus.grant_node  <= grant_nx;
      bus.drop_count  <= drop_nx;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one low-to-high and one high-to-low segment.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned D = 3;

  logic clk = 1'b0;
  logic reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NODE_COUNT(N), .NODE_COUNT_DIGIT(D), .DROP_CNT_W(8)) bus0 ();
  bus_arbiter_if #(.NODE_COUNT(N), .NODE_COUNT_DIGIT(D), .DROP_CNT_W(8)) bus1 ();

  bus_arbiter #(.NODE_COUNT(N), .NODE_COUNT_DIGIT(D), .DIRECTION(0), .DROP_CNT_W(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  bus_arbiter #(.NODE_COUNT(N), .NODE_COUNT_DIGIT(D), .DIRECTION(1), .DROP_CNT_W(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  function automatic logic [N*3-1:0] slice1(int unsigned n, logic [2:0] code);
    logic [N*3-1:0] v;
    v = '0;
    v[n*3 +: 3] = code;
    return v;
  endfunction

  function automatic logic [N*(D+1)-1:0] req1(int unsigned n, int unsigned dest);
    logic [N*(D+1)-1:0] v;
    v = '0;
    v[n*(D+1) +: D+1] = {1'b1, D'(dest)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [N*3-1:0] ctrl, input logic busy);
    chk({tag, ".ctrl"}, 32'(bus0.control_out), 32'(ctrl));
    chk({tag, ".busy"}, 32'(bus0.busy), 32'(busy));
  endtask

  task automatic chk1(input string tag, input logic [N*3-1:0] ctrl, input logic busy);
    chk({tag, ".ctrl"}, 32'(bus1.control_out), 32'(ctrl));
    chk({tag, ".busy"}, 32'(bus1.busy), 32'(busy));
  endtask

  int unsigned order [6] = '{1, 4, 6, 1, 4, 6};
  int unsigned exp_drop;

  initial begin
    reset = 1'b1;
    bus0.request_in = '0;
    bus1.request_in = '0;
    #1 reset = 1'b0;
    #1;
    chk0("rst", '0, 1'b0);
    chk("rst.grant", 32'(bus0.grant_node), 32'd0);
    chk("rst.drop", 32'(bus0.drop_count), 32'd0);
    chk1("rst1", '0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk0("idle", '0, 1'b0);

    // Round-robin fairness, first search from node 0
    bus0.request_in = req1(1, 2) | req1(4, 5) | req1(6, 7);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      chk0($sformatf("rr%0d.tx", g), slice1(order[g], CTRL_TX), 1'b1);
      chk($sformatf("rr%0d.grant", g), 32'(bus0.grant_node), order[g]);
      if (g == 5) bus0.request_in = '0;
      @(negedge clk);
      chk0($sformatf("rr%0d.rx", g), slice1(order[g] + 1, CTRL_RX), 1'b1);
      @(negedge clk);
      chk0($sformatf("rr%0d.cool", g), '0, 1'b1);
      @(negedge clk);
      chk0($sformatf("rr%0d.idle", g), '0, 1'b0);
    end
    @(negedge clk);
    chk0("rr.quiet", '0, 1'b0);

    // Single request 2 -> 5, with an illegal request arriving mid-transfer
    bus0.request_in = req1(2, 5);
    @(negedge clk);
    chk0("s.tx2", slice1(2, CTRL_TX), 1'b1);
    chk("s.grant", 32'(bus0.grant_node), 32'd2);
    bus0.request_in = '0;
    @(negedge clk);
    chk0("s.byp3", slice1(3, CTRL_BYP), 1'b1);
    bus0.request_in = req1(7, 1);
    @(negedge clk);
    chk0("s.byp4", slice1(4, CTRL_BYP), 1'b1);
    @(negedge clk);
    chk0("s.rx5", slice1(5, CTRL_RX), 1'b1);
    bus0.request_in = '0;
    @(negedge clk);
    chk0("s.cool", '0, 1'b1);
    chk("s.nodrop", 32'(bus0.drop_count), 32'd0);
    @(negedge clk);
    chk0("s.idle", '0, 1'b0);
    chk("s.grant_hold", 32'(bus0.grant_node), 32'd2);
    chk("s.nodrop2", 32'(bus0.drop_count), 32'd0);

    // Adjacent hop 6 -> 7
    bus0.request_in = req1(6, 7);
    @(negedge clk);
    chk0("a.tx6", slice1(6, CTRL_TX), 1'b1);
    bus0.request_in = '0;
    @(negedge clk);
    chk0("a.rx7", slice1(7, CTRL_RX), 1'b1);
    @(negedge clk);
    chk0("a.cool", '0, 1'b1);
    @(negedge clk);
    chk0("a.idle", '0, 1'b0);

    // Illegal requests: backward and self-addressed, counter saturates
    bus0.request_in = req1(5, 3) | req1(7, 7);
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      exp_drop = (2 * k > 255) ? 255 : 2 * k;
      if (k == 1 || k == 2 || k == 127 || k == 128 || k == 130)
        chk($sformatf("drop.k%0d", k), 32'(bus0.drop_count), exp_drop);
      if (k == 2 || k == 130) begin
        chk0($sformatf("drop.k%0d", k), '0, 1'b0);
        chk($sformatf("drop.grant%0d", k), 32'(bus0.grant_node), 32'd6);
      end
    end
    bus0.request_in = '0;
    @(negedge clk);
    chk("drop.sat_hold", 32'(bus0.drop_count), 32'd255);

    // Reset during PROP of 0 -> 7
    bus0.request_in = req1(0, 7);
    @(negedge clk);
    chk0("r.tx0", slice1(0, CTRL_TX), 1'b1);
    bus0.request_in = '0;
    @(negedge clk);
    chk0("r.byp1", slice1(1, CTRL_BYP), 1'b1);
    @(negedge clk);
    chk0("r.byp2", slice1(2, CTRL_BYP), 1'b1);
    #2 reset = 1'b0;
    #1;
    chk0("r.async", '0, 1'b0);
    chk("r.grant", 32'(bus0.grant_node), 32'd0);
    chk("r.drop", 32'(bus0.drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk0("r.abandon", '0, 1'b0);
    bus0.request_in = req1(0, 1) | req1(3, 4);
    @(negedge clk);
    chk0("r.tx_first", slice1(0, CTRL_TX), 1'b1);
    chk("r.grant0", 32'(bus0.grant_node), 32'd0);
    bus0.request_in = '0;
    @(negedge clk);
    chk0("r.rx1", slice1(1, CTRL_RX), 1'b1);
    @(negedge clk);
    chk0("r.cool", '0, 1'b1);
    @(negedge clk);
    chk0("r.idle", '0, 1'b0);

    // High-to-low segment: 7 -> 0
    bus1.request_in = req1(7, 0);
    @(negedge clk);
    chk1("d1.tx7", slice1(7, CTRL_TX), 1'b1);
    chk("d1.grant", 32'(bus1.grant_node), 32'd7);
    bus1.request_in = '0;
    for (int h = 1; h <= 7; h++) begin
      @(negedge clk);
      if (h < 7) chk1($sformatf("d1.byp%0d", 7 - h), slice1(7 - h, CTRL_BYP), 1'b1);
      else       chk1("d1.rx0", slice1(0, CTRL_RX), 1'b1);
    end
    @(negedge clk);
    chk1("d1.cool", '0, 1'b1);
    @(negedge clk);
    chk1("d1.idle", '0, 1'b0);
    chk0("d0.quiet", '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
